// File: rtl/pipe_stage_reg.sv
// Parametrised inter-stage pipeline register with valid, stall/flush control and
// optional saturating stall/flush counters (enabled by defining PIPE_STAGE_PERF_EN).
module pipe_stage_reg #(
  parameter int DATA_W   = 64,
  parameter int NUM_DATA = 2,
  parameter int RD_W     = 5,
  parameter int CTRL_W   = 4,
  parameter int WE_BIT   = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       stall,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic [NUM_DATA*DATA_W-1:0] in_data,
  input  logic [RD_W-1:0]            in_rd,
  input  logic [CTRL_W-1:0]          in_ctrl,
  output logic                       out_valid,
  output logic [NUM_DATA*DATA_W-1:0] out_data,
  output logic [RD_W-1:0]            out_rd,
  output logic [CTRL_W-1:0]          out_ctrl,
  output logic                       out_wr_en,
  output logic [31:0]                stall_cnt,
  output logic [31:0]                flush_cnt
);

  logic                             valid_d, valid_q;
  logic [NUM_DATA-1:0][DATA_W-1:0]  data_d, data_q;
  logic [RD_W-1:0]                  rd_d, rd_q;
  logic [CTRL_W-1:0]                ctrl_d, ctrl_q;

  // Flush keeps the data payload: only valid/rd/ctrl need to be clean for a bubble.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    rd_d    = rd_q;
    ctrl_d  = ctrl_q;
    if (flush) begin
      valid_d = 1'b0;
      rd_d    = '0;
      ctrl_d  = '0;
    end else if (!stall) begin
      valid_d = in_valid;
      data_d  = in_data;
      rd_d    = in_rd;
      ctrl_d  = in_valid ? in_ctrl : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      rd_q    <= '0;
      ctrl_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      rd_q    <= rd_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_rd    = rd_q;
  assign out_ctrl  = ctrl_q;
  assign out_wr_en = valid_q & ctrl_q[WE_BIT];

`ifdef PIPE_STAGE_PERF_EN
  logic [31:0] stall_cnt_d, stall_cnt_q;
  logic [31:0] flush_cnt_d, flush_cnt_q;

  // Saturating counts; a stall masked by flush is counted only as a flush.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (flush) begin
      if (flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + 32'd1;
    end else if (stall) begin
      if (stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = 32'd0;
  assign flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Randomized + directed bench for pipe_stage_reg against a cycle-level reference model.
module tb_pipe_stage_reg;
  localparam int DATA_W = 64, NUM_DATA = 2, RD_W = 5, CTRL_W = 4, WE_BIT = 2;
  localparam int DW = DATA_W * NUM_DATA;
`ifdef PIPE_STAGE_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1, stall = 1'b0, flush = 1'b0, in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic [RD_W-1:0] in_rd = '0;
  logic [CTRL_W-1:0] in_ctrl = '0;
  logic out_valid, out_wr_en;
  logic [DW-1:0] out_data;
  logic [RD_W-1:0] out_rd;
  logic [CTRL_W-1:0] out_ctrl;
  logic [31:0] stall_cnt, flush_cnt;

  int checks = 0, errors = 0;

  pipe_stage_reg #(.DATA_W(DATA_W), .NUM_DATA(NUM_DATA), .RD_W(RD_W),
                   .CTRL_W(CTRL_W), .WE_BIT(WE_BIT)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_rd(in_rd), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_data(out_data), .out_rd(out_rd),
    .out_ctrl(out_ctrl), .out_wr_en(out_wr_en),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Reference state: what the stage must hold after each edge.
  bit            live = 1'b0;
  bit            m_valid;
  logic [DW-1:0] m_data;
  logic [RD_W-1:0] m_rd;
  logic [CTRL_W-1:0] m_ctrl;
  longint        m_stall, m_flush;
  int            ptok = 0, pseen = 0;
  localparam longint CMAX = 64'h0000_0000_FFFF_FFFF;

  always @(posedge clk) begin
    if (ptok != pseen) begin
      m_stall = 64'h0000_0000_FFFF_FFFE;
      pseen   = ptok;
    end
    if (reset) begin
      live = 1'b1;
      m_valid = 1'b0; m_data = '0; m_rd = '0; m_ctrl = '0;
      m_stall = 0; m_flush = 0;
    end else if (flush) begin
      m_valid = 1'b0; m_rd = '0; m_ctrl = '0;
      m_flush = (m_flush + 1 > CMAX) ? CMAX : m_flush + 1;
    end else if (stall) begin
      m_stall = (m_stall + 1 > CMAX) ? CMAX : m_stall + 1;
    end else begin
      m_valid = in_valid; m_data = in_data; m_rd = in_rd;
      m_ctrl  = in_valid ? in_ctrl : '0;
    end
  end

  always @(negedge clk) begin
    if (live) begin
      chk("out_valid", 128'(out_valid), 128'(m_valid));
      chk("out_data",  128'(out_data),  128'(m_data));
      chk("out_rd",    128'(out_rd),    128'(m_rd));
      chk("out_ctrl",  128'(out_ctrl),  128'(m_ctrl));
      chk("out_wr_en", 128'(out_wr_en), 128'(m_valid && m_ctrl[WE_BIT]));
      chk("stall_cnt", 128'(stall_cnt), PERF ? 128'(m_stall[31:0]) : 128'd0);
      chk("flush_cnt", 128'(flush_cnt), PERF ? 128'(m_flush[31:0]) : 128'd0);
      if (!out_valid) chk("bubble_ctrl", 128'({out_ctrl, out_wr_en}), 128'd0);
    end
  end

  task automatic cyc(input bit rs, st, fl, v, input logic [DW-1:0] d,
                     input logic [RD_W-1:0] rd, input logic [CTRL_W-1:0] c);
    @(negedge clk);
    reset = rs; stall = st; flush = fl; in_valid = v;
    in_data = d; in_rd = rd; in_ctrl = c;
    @(posedge clk);
    #1;
  endtask

  logic [DW-1:0] da, db, dx, rnd;

  initial begin
    da = {64'h1234, 64'hABCD};
    db = {64'hBEEF_0000_0000_0001, 64'hCAFE_0000_0000_0002};
    dx = {64'h5555, 64'h7777};

    cyc(1, 0, 0, 0, '0, '0, '0);
    cyc(1, 0, 0, 0, '0, '0, '0);
    chk("rst_valid", 128'(out_valid), 128'd0);
    chk("rst_cnt",   128'({stall_cnt, flush_cnt}), 128'd0);

    cyc(0, 0, 0, 1, da, 5'd5, 4'b0101);
    chk("load_valid", 128'(out_valid), 128'd1);
    chk("load_rd",    128'(out_rd),    128'd5);
    chk("load_ctrl",  128'(out_ctrl),  128'(4'b0101));
    chk("load_we",    128'(out_wr_en), 128'd1);
    chk("load_data",  128'(out_data),  {64'h1234, 64'hABCD});

    cyc(0, 0, 0, 0, dx, 5'd7, 4'b1111);
    chk("inv_valid", 128'(out_valid), 128'd0);
    chk("inv_ctrl",  128'(out_ctrl),  128'd0);
    chk("inv_we",    128'(out_wr_en), 128'd0);
    chk("inv_data",  128'(out_data),  {64'h5555, 64'h7777});

    // Stall for 3 edges with B presented; A must survive.
    cyc(1, 0, 0, 0, '0, '0, '0);
    cyc(0, 0, 0, 1, da, 5'd5, 4'b0101);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 0, 1, db, 5'd9, 4'b0110);
      chk("stall_rd",   128'(out_rd),   128'd5);
      chk("stall_data", 128'(out_data), {64'h1234, 64'hABCD});
    end
    chk("stall_cnt3", 128'(stall_cnt), PERF ? 128'd3 : 128'd0);
    cyc(0, 0, 0, 1, db, 5'd9, 4'b0110);
    chk("after_stall_rd",   128'(out_rd),   128'd9);
    chk("after_stall_ctrl", 128'(out_ctrl), 128'(4'b0110));

    // Flush beats stall, data payload held.
    cyc(0, 1, 1, 1, da, 5'd3, 4'b0100);
    chk("fl_valid", 128'(out_valid), 128'd0);
    chk("fl_rdctl", 128'({out_rd, out_ctrl}), 128'd0);
    chk("fl_data",  128'(out_data), {64'hBEEF_0000_0000_0001, 64'hCAFE_0000_0000_0002});
    chk("fl_cnt",   128'(flush_cnt), PERF ? 128'd1 : 128'd0);
    chk("fl_scnt",  128'(stall_cnt), PERF ? 128'd3 : 128'd0);

    // Saturation: preload the counter near the top, then keep stalling.
    @(negedge clk);
    reset = 0; stall = 1; flush = 0;
`ifdef PIPE_STAGE_PERF_EN
    #1;
    force dut.stall_cnt_q = 32'hFFFF_FFFE;
    ptok++;
    #1;
    release dut.stall_cnt_q;
`endif
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 1, dx, 5'd1, 4'b0100);
    chk("sat_cnt", 128'(stall_cnt), PERF ? 128'hFFFF_FFFF : 128'd0);

    // Reset during a stall with valid contents.
    cyc(0, 0, 0, 1, da, 5'd5, 4'b0101);
    cyc(0, 1, 0, 1, db, 5'd9, 4'b0110);
    cyc(1, 1, 0, 1, db, 5'd9, 4'b0110);
    chk("rst_stall_out", 128'({out_valid, out_rd, out_ctrl, out_wr_en}), 128'd0);
    chk("rst_stall_dat", 128'(out_data), 128'd0);
    chk("rst_stall_cnt", 128'({stall_cnt, flush_cnt}), 128'd0);

    for (int i = 0; i < 600; i++) begin
      rnd = {$urandom, $urandom, $urandom, $urandom};
      cyc(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) == 0),
          ($urandom_range(0, 9) == 0), 1'($urandom),
          rnd, RD_W'($urandom), CTRL_W'($urandom));
    end

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
